// File: rtl/bus_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 data mux, with a one-entry registered output stage.
// Latency: req in cycle 0 -> grant/sel in cycle 1 -> out_valid from cycle 2; 1 beat/clk within a grant.
// Backpressure: out_valid && !out_ready stalls the grant (no ack, count frozen); each grant capped at BURST_MAX beats.
module bus_mux_arbiter #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [3:0]       req_ack,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [3:0]       cnt_q;
    logic [3:0]       grant_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic [WIDTH-1:0] src_dat;
    logic             free;
    logic             take;
    logic             last_beat;
    logic             rel;
    logic             pick_vld;
    logic [1:0]       pick_sel_d;
    logic [1:0]       scan_idx;

    always_comb begin
        unique case (sel_q)
            2'b00:   src_dat = d1;
            2'b01:   src_dat = d2;
            2'b10:   src_dat = d3;
            default: src_dat = d4;
        endcase
    end

    // The output slot is free if empty or being drained this same edge.
    assign free      = !out_valid_q || out_ready;
    assign take      = (state_q == GRANT) && req[sel_q] && free;
    assign last_beat = (cnt_q == 4'(BURST_MAX - 1));
    assign rel       = (state_q == GRANT) && (!req[sel_q] || (take && last_beat));

    // Scan from ptr upward; iterating downward leaves the closest requester as the winner.
    always_comb begin
        pick_vld   = 1'b0;
        pick_sel_d = ptr_q;
        scan_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req[scan_idx]) begin
                pick_vld   = 1'b1;
                pick_sel_d = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            sel_q       <= 2'd0;
            cnt_q       <= 4'd0;
            grant_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (pick_vld) begin
                        sel_q   <= pick_sel_d;
                        grant_q <= 4'b0001 << pick_sel_d;
                        cnt_q   <= 4'd0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (take) begin
                        out_data_q  <= src_dat;
                        out_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + 4'd1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (rel) begin
                        grant_q <= 4'd0;
                        ptr_q   <= sel_q + 2'd1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign req_ack   = take ? grant_q : 4'b0000;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed bench for bus_mux_arbiter: vector table plus hand sequences for reset and round robin.
module tb_bus_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] d1, d2, d3, d4;
    logic        out_ready;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic [3:0]  req_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] dat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign d1 = 32'h1111_0000 | {16'h0, dat};
    assign d2 = 32'h2222_0000 | {16'h0, dat};
    assign d3 = 32'hA5A5_0000 | {16'h0, dat};
    assign d4 = 32'h4444_0000 | {16'h0, dat};

    bus_mux_arbiter #(.WIDTH(32), .BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .req_ack   (req_ack),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [15:0] dat;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic [3:0]  ack;
        logic        vld;
        logic [31:0] data;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] tags[4];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic [3:0] ea, input logic ev, input logic [31:0] ed);
        cmp({name, ".grant"}, {28'h0, grant}, {28'h0, eg});
        cmp({name, ".sel"}, {30'h0, sel}, {30'h0, es});
        cmp({name, ".req_ack"}, {28'h0, req_ack}, {28'h0, ea});
        cmp({name, ".out_valid"}, {31'h0, out_valid}, {31'h0, ev});
        cmp({name, ".out_data"}, out_data, ed);
        cmp({name, ".onehot0"}, {31'h0, $onehot0(grant)}, 32'd1);
    endtask

    task automatic step(input logic [3:0] r, input logic rdy, input logic [15:0] dv,
                        input logic [3:0] eg, input logic [1:0] es, input logic [3:0] ea,
                        input logic ev, input logic [31:0] ed, input string name);
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        dat       = dv;
        #1;
        check(name, eg, es, ea, ev, ed);
    endtask

    initial begin
        tags[0] = 32'h1111_0000;
        tags[1] = 32'h2222_0000;
        tags[2] = 32'hA5A5_0000;
        tags[3] = 32'h4444_0000;

        // req, rdy, dat | grant, sel, ack, vld, data (registered state seen before the next edge)
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd1, 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h0});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd1, 4'b0100, 2'd2, 4'b0100, 1'b0, 32'h0});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd2, 4'b0100, 2'd2, 4'b0100, 1'b1, 32'hA5A5_0001});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd3, 4'b0100, 2'd2, 4'b0100, 1'b1, 32'hA5A5_0002});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd4, 4'b0100, 2'd2, 4'b0100, 1'b1, 32'hA5A5_0003});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd5, 4'b0000, 2'd2, 4'b0000, 1'b1, 32'hA5A5_0004});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd5, 4'b0100, 2'd2, 4'b0100, 1'b0, 32'hA5A5_0004});
        tbl.push_back(vec_t'{4'b0000, 1'b1, 16'd6, 4'b0100, 2'd2, 4'b0000, 1'b1, 32'hA5A5_0005});
        tbl.push_back(vec_t'{4'b0000, 1'b1, 16'd6, 4'b0000, 2'd2, 4'b0000, 1'b0, 32'hA5A5_0005});
        // d2 stream with three stalled cycles after the first beat
        tbl.push_back(vec_t'{4'b0010, 1'b1, 16'd1, 4'b0000, 2'd2, 4'b0000, 1'b0, 32'hA5A5_0005});
        tbl.push_back(vec_t'{4'b0010, 1'b1, 16'd1, 4'b0010, 2'd1, 4'b0010, 1'b0, 32'hA5A5_0005});
        tbl.push_back(vec_t'{4'b0010, 1'b0, 16'd2, 4'b0010, 2'd1, 4'b0000, 1'b1, 32'h2222_0001});
        tbl.push_back(vec_t'{4'b0010, 1'b0, 16'd2, 4'b0010, 2'd1, 4'b0000, 1'b1, 32'h2222_0001});
        tbl.push_back(vec_t'{4'b0010, 1'b0, 16'd2, 4'b0010, 2'd1, 4'b0000, 1'b1, 32'h2222_0001});
        tbl.push_back(vec_t'{4'b0010, 1'b1, 16'd2, 4'b0010, 2'd1, 4'b0010, 1'b1, 32'h2222_0001});
        tbl.push_back(vec_t'{4'b0010, 1'b1, 16'd3, 4'b0010, 2'd1, 4'b0010, 1'b1, 32'h2222_0002});
        tbl.push_back(vec_t'{4'b0010, 1'b1, 16'd4, 4'b0010, 2'd1, 4'b0010, 1'b1, 32'h2222_0003});
        tbl.push_back(vec_t'{4'b0000, 1'b0, 16'd5, 4'b0000, 2'd1, 4'b0000, 1'b1, 32'h2222_0004});
        tbl.push_back(vec_t'{4'b0000, 1'b1, 16'd5, 4'b0000, 2'd1, 4'b0000, 1'b1, 32'h2222_0004});
        // d1 drops after two beats; pointer then skips d1 in favour of d4
        tbl.push_back(vec_t'{4'b0001, 1'b1, 16'd1, 4'b0000, 2'd1, 4'b0000, 1'b0, 32'h2222_0004});
        tbl.push_back(vec_t'{4'b0001, 1'b1, 16'd1, 4'b0001, 2'd0, 4'b0001, 1'b0, 32'h2222_0004});
        tbl.push_back(vec_t'{4'b0001, 1'b1, 16'd2, 4'b0001, 2'd0, 4'b0001, 1'b1, 32'h1111_0001});
        tbl.push_back(vec_t'{4'b1000, 1'b1, 16'd3, 4'b0001, 2'd0, 4'b0000, 1'b1, 32'h1111_0002});
        tbl.push_back(vec_t'{4'b1001, 1'b1, 16'd3, 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h1111_0002});
        tbl.push_back(vec_t'{4'b1001, 1'b1, 16'd3, 4'b1000, 2'd3, 4'b1000, 1'b0, 32'h1111_0002});
        // d4 releases while d1 and d3 rise: pointer wraps to 0
        tbl.push_back(vec_t'{4'b0101, 1'b1, 16'd4, 4'b1000, 2'd3, 4'b0000, 1'b1, 32'h4444_0003});
        tbl.push_back(vec_t'{4'b0101, 1'b1, 16'd4, 4'b0000, 2'd3, 4'b0000, 1'b0, 32'h4444_0003});
        tbl.push_back(vec_t'{4'b0101, 1'b1, 16'd4, 4'b0001, 2'd0, 4'b0001, 1'b0, 32'h4444_0003});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd5, 4'b0001, 2'd0, 4'b0000, 1'b1, 32'h1111_0004});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd5, 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h1111_0004});
        tbl.push_back(vec_t'{4'b0100, 1'b1, 16'd5, 4'b0100, 2'd2, 4'b0100, 1'b0, 32'h1111_0004});
        tbl.push_back(vec_t'{4'b0000, 1'b1, 16'd0, 4'b0100, 2'd2, 4'b0000, 1'b1, 32'hA5A5_0005});
        tbl.push_back(vec_t'{4'b0000, 1'b1, 16'd0, 4'b0000, 2'd2, 4'b0000, 1'b0, 32'hA5A5_0005});

        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        dat       = 16'h0;
        #1;
        check("reset", 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].rdy, tbl[i].dat, tbl[i].grant, tbl[i].sel,
                 tbl[i].ack, tbl[i].vld, tbl[i].data, $sformatf("row%0d", i));
        end

        // Asynchronous reset in the middle of a d2 burst
        step(4'b0010, 1'b1, 16'd1, 4'b0000, 2'd2, 4'b0000, 1'b0, 32'hA5A5_0005, "t1_idle");
        step(4'b0010, 1'b1, 16'd1, 4'b0010, 2'd1, 4'b0010, 1'b0, 32'hA5A5_0005, "t1_b1");
        step(4'b0010, 1'b1, 16'd2, 4'b0010, 2'd1, 4'b0010, 1'b1, 32'h2222_0001, "t1_b2");
        step(4'b0010, 1'b1, 16'd3, 4'b0010, 2'd1, 4'b0010, 1'b1, 32'h2222_0002, "t1_b3");
        rst_n = 1'b0;
        #1;
        check("t1_async", 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("t1_held", 4'b0000, 2'd0, 4'b0000, 1'b0, 32'h0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // All four requesting from ptr=0: d1,d2,d3,d4,d1 with 4 beats each
        for (int g = 0; g < 5; g++) begin
            int          s;
            logic [31:0] prevd;
            logic [1:0]  prevs;
            s     = g % 4;
            prevd = (g == 0) ? 32'h0 : tags[(g - 1) % 4] + 32'd4;
            prevs = (g == 0) ? 2'd0 : 2'((g - 1) % 4);
            step(4'b1111, 1'b1, 16'd0, 4'b0000, prevs, 4'b0000, (g > 0), prevd,
                 $sformatf("rr%0d_idle", g));
            for (int b = 1; b <= 4; b++) begin
                step(4'b1111, 1'b1, 16'(b), 4'(1 << s), 2'(s), 4'(1 << s), (b > 1),
                     (b == 1) ? prevd : tags[s] + 32'(b - 1), $sformatf("rr%0d_b%0d", g, b));
            end
        end
        step(4'b0000, 1'b1, 16'd0, 4'b0000, 2'd0, 4'b0000, 1'b1, tags[0] + 32'd4, "rr_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
